// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Purpose  : Shared definitions for the Hamming (16,11) SECDED encode
//             sequencer: sequencer state encoding, codeword bit positions
//             and the reference parity function used by the encoder.
//  Contents : seq_state_t     - sequencer state enum (3-bit)
//             c_pos_*         - codeword bit positions
//             hamming_parity  - 11-bit message -> 16-bit SECDED codeword
//  Revision : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Sequencer states. Values are fixed so the encoding is stable across
    // tools and visible in waveforms.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_LO = 3'd1,
        S_RD_HI = 3'd2,
        S_ENC   = 3'd3,
        S_WR_LO = 3'd4,
        S_WR_HI = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

    // Codeword layout: cw = {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
    // Parity bits sit at the power-of-two positions, p0 is overall parity.
    localparam int c_pos_p0 = 0;
    localparam int c_pos_p1 = 1;
    localparam int c_pos_p2 = 2;
    localparam int c_pos_d1 = 3;
    localparam int c_pos_p4 = 4;
    localparam int c_pos_d2 = 5;    // d4..d2 occupy positions 7..5
    localparam int c_pos_p8 = 8;
    localparam int c_pos_d5 = 9;    // d11..d5 occupy positions 15..9

    // Message bits are numbered 1..11 to match the usual Hamming notation.
    function automatic logic [15:0] hamming_parity(input logic [11:1] d);
        logic        p8;
        logic        p4;
        logic        p2;
        logic        p1;
        logic        p0;
        logic [15:0] cw;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9]  ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        // Overall parity over data and Hamming parity gives double-error
        // detection on the decode side.
        p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;

        cw                  = '0;
        cw[c_pos_d5 +: 7]   = d[11:5];
        cw[c_pos_p8]        = p8;
        cw[c_pos_d2 +: 3]   = d[4:2];
        cw[c_pos_p4]        = p4;
        cw[c_pos_d1]        = d[1];
        cw[c_pos_p2]        = p2;
        cw[c_pos_p1]        = p1;
        cw[c_pos_p0]        = p0;
        return cw;
    endfunction

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_enc11.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_enc11
//  Purpose  : Purely combinational Hamming (16,11) SECDED encoder.
//  Ports    : i_d  [11:1] in   message bits d11..d1
//             o_cw [15:0] out  encoded codeword
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_enc11
    import hamming_pkg::*;
(
    input  logic [11:1] i_d,
    output logic [15:0] o_cw
);

    assign o_cw = hamming_parity(i_d);

endmodule : hamming_enc11
`default_nettype wire

// File: rtl/hamming_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_enc_seq
//  Purpose  : Memory-walking sequencer for Hamming (16,11) encode. On an
//             accepted Start it reads NUM_MSG 11-bit messages (byte pairs at
//             SRC_BASE), encodes each and writes the 16-bit codeword back as
//             a byte pair at DST_BASE, then raises Done. It owns the single
//             data-memory port while Busy.
//  Ports    : Clk         in   system clock, rising edge
//             Reset       in   asynchronous active-low reset
//             Start       in   run request, level-sampled in IDLE/DONE
//             Done        out  run complete, held until next accepted Start
//             Busy        out  sequencer owns the memory port
//             Mem_Addr    out  memory byte address (modulo 2^AW)
//             Mem_WrEn    out  memory write strobe
//             Mem_WrData  out  memory write data
//             Mem_RdData  in   memory read data, one cycle after Mem_Addr
//             Cycle_Cnt   out  busy-cycle counter (only with the macro below)
//  Options  : HAMMING_SEQ_CYCLE_CNT_EN - adds the saturating Cycle_Cnt output
//  Revision : 1.0 - initial release
// ============================================================================
module hamming_enc_seq
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int AW       = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Done,
    output logic          Busy,
    output logic [AW-1:0] Mem_Addr,
    output logic          Mem_WrEn,
    output logic [7:0]    Mem_WrData,
    input  logic [7:0]    Mem_RdData
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]   Cycle_Cnt
`endif
);

    localparam int c_iw = $clog2(NUM_MSG + 1);

    seq_state_t      r_state;
    logic [c_iw-1:0] r_idx;
    logic [7:0]      r_lo;          // d[8:1], captured from the low byte
    logic [7:0]      r_cw_hi;       // upper codeword byte, written in WR_HI
    logic            r_done;
    logic            r_busy;
    logic [AW-1:0]   r_addr;
    logic            r_wr_en;
    logic [7:0]      r_wr_data;

    logic [c_iw-1:0] w_idx_inc;
    logic            w_last;
    logic [AW-1:0]   w_src_lo;
    logic [AW-1:0]   w_src_lo_next;
    logic [AW-1:0]   w_dst_lo;
    logic [15:0]     w_cw;

    assign w_idx_inc = r_idx + c_iw'(1);
    assign w_last    = (r_idx == c_iw'(NUM_MSG - 1));

    // Byte addresses for the current and next message; all arithmetic
    // wraps naturally at AW bits.
    assign w_src_lo      = AW'(SRC_BASE) + AW'({r_idx, 1'b0});
    assign w_src_lo_next = AW'(SRC_BASE) + AW'({w_idx_inc, 1'b0});
    assign w_dst_lo      = AW'(DST_BASE) + AW'({r_idx, 1'b0});

    // The encoder sees the high byte straight off the read bus during ENC,
    // so the codeword is ready on the same edge that captures d[11:9].
    // Bits [7:3] of the high byte are not part of the message.
    hamming_enc11 u_enc (
        .i_d  ({Mem_RdData[2:0], r_lo}),
        .o_cw (w_cw)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_lo      <= '0;
            r_cw_hi   <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            r_wr_en <= 1'b0;

            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state <= S_RD_LO;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= AW'(SRC_BASE);
                    end
                end

                S_RD_LO: begin
                    r_state <= S_RD_HI;
                    r_addr  <= w_src_lo + AW'(1);
                end

                S_RD_HI: begin
                    // Low byte addressed during RD_LO is on the bus now.
                    r_lo    <= Mem_RdData;
                    r_state <= S_ENC;
                end

                S_ENC: begin
                    r_cw_hi   <= w_cw[15:8];
                    r_state   <= S_WR_LO;
                    r_wr_en   <= 1'b1;
                    r_addr    <= w_dst_lo;
                    r_wr_data <= w_cw[7:0];
                end

                S_WR_LO: begin
                    r_state   <= S_WR_HI;
                    r_wr_en   <= 1'b1;
                    r_addr    <= w_dst_lo + AW'(1);
                    r_wr_data <= r_cw_hi;
                end

                S_WR_HI: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD_LO;
                        r_idx   <= w_idx_inc;
                        r_addr  <= w_src_lo_next;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign Done       = r_done;
    assign Busy       = r_busy;
    assign Mem_Addr   = r_addr;
    assign Mem_WrEn   = r_wr_en;
    assign Mem_WrData = r_wr_data;

`ifdef HAMMING_SEQ_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic        w_start_acc;

    assign w_start_acc = Start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Counts cycles with Busy high; naturally holds once DONE drops Busy.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt <= '0;
        end else if (r_busy && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign Cycle_Cnt = r_cycle_cnt;
`endif

endmodule : hamming_enc_seq
`default_nettype wire

// File: tb/tb_hamming_enc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hamming_enc_seq
//  Purpose  : Self-checking bench for hamming_enc_seq with a synchronous
//             byte memory and a position-based Hamming reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hamming_enc_seq;

    localparam int NUM_MSG  = 15;
    localparam int SRC_BASE = 0;
    localparam int DST_BASE = 30;
    localparam int AW       = 8;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Start;
    logic          Done;
    logic          Busy;
    logic [AW-1:0] Mem_Addr;
    logic          Mem_WrEn;
    logic [7:0]    Mem_WrData;
    logic [7:0]    Mem_RdData;
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
    logic [15:0]   Cycle_Cnt;
`endif

    // Bench-side load port into the memory model
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [7:0]    tb_data;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    lo_b [NUM_MSG];
    logic [7:0]    hi_b [NUM_MSG];

    int checks   = 0;
    int failures = 0;

    hamming_enc_seq #(
        .NUM_MSG  (NUM_MSG),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE),
        .AW       (AW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Done       (Done),
        .Busy       (Busy),
        .Mem_Addr   (Mem_Addr),
        .Mem_WrEn   (Mem_WrEn),
        .Mem_WrData (Mem_WrData),
        .Mem_RdData (Mem_RdData)
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
        ,
        .Cycle_Cnt  (Cycle_Cnt)
`endif
    );

    always #5 Clk = ~Clk;

    // Synchronous-read byte memory; DUT writes take priority over loading.
    always @(posedge Clk) begin
        if (Mem_WrEn)
            mem[Mem_Addr] <= Mem_WrData;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
        Mem_RdData <= mem[Mem_Addr];
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: data bits fill the non-power-of-two positions 3..15 in
    // order; each parity at position p covers every position with bit p set;
    // position 0 makes the whole word even parity.
    function automatic logic [15:0] ref_cw(input logic [10:0] d);
        logic [15:0] cw;
        logic        x;
        int          j;
        cw = '0;
        j  = 0;
        for (int pos = 3; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[j];
                j++;
            end
        end
        for (int p = 1; p < 16; p = p * 2) begin
            x = 1'b0;
            for (int pos = 1; pos < 16; pos++)
                if (((pos & p) != 0) && (pos != p))
                    x = x ^ cw[pos];
            cw[p] = x;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic mem_wr(input int a, input logic [7:0] d);
        tb_we   = 1'b1;
        tb_addr = AW'(a);
        tb_data = d;
        @(posedge Clk);
        #1;
        tb_we   = 1'b0;
    endtask

    task automatic randomize_msgs();
        for (int k = 0; k < NUM_MSG; k++) begin
            lo_b[k] = 8'($urandom);
            hi_b[k] = 8'($urandom);   // upper bits deliberately junk
        end
    endtask

    task automatic load_mem();
        for (int k = 0; k < NUM_MSG; k++) begin
            mem_wr(SRC_BASE + 2*k,     lo_b[k]);
            mem_wr(SRC_BASE + 2*k + 1, hi_b[k]);
            mem_wr(DST_BASE + 2*k,     8'hAA);
            mem_wr(DST_BASE + 2*k + 1, 8'hAA);
        end
    endtask

    task automatic check_results(input string run);
        logic [15:0] got;
        for (int k = 0; k < NUM_MSG; k++) begin
            got = {mem[DST_BASE + 2*k + 1], mem[DST_BASE + 2*k]};
            chk_eq($sformatf("%s_cw%0d", run, k), 32'(got), 32'(ref_cw({hi_b[k][2:0], lo_b[k]})));
        end
    endtask

    // Runs one sequence; edge 1 is the edge that samples Start.
    task automatic run_seq(input bit hold, output int done_edge, output int strobes,
                           output int low_wr, output int busy_gap);
        int n;
        done_edge = -1;
        strobes   = 0;
        low_wr    = 0;
        busy_gap  = 0;
        n         = 0;
        Start     = 1'b1;
        while (n < 200) begin
            @(posedge Clk);
            n++;
            #1;
            if (hold) Start = (n < 20) || (n >= 40 && n < 43);
            else      Start = 1'b0;
            if (Mem_WrEn) begin
                strobes++;
                if (Mem_Addr < AW'(DST_BASE)) low_wr++;
            end
            if (Done) begin
                done_edge = n;
                break;
            end
            if (!Busy) busy_gap++;
        end
        Start = 1'b0;
    endtask

    int de, st, lw, bg;
    int found;

    initial begin
        Reset = 1'b0;
        Start = 1'b0;
        tb_we = 1'b0;
        tb_addr = '0;
        tb_data = '0;
        repeat (3) @(posedge Clk);
        #1;
        chk_eq("rst_done",   32'(Done),       0);
        chk_eq("rst_busy",   32'(Busy),       0);
        chk_eq("rst_wren",   32'(Mem_WrEn),   0);
        chk_eq("rst_addr",   32'(Mem_Addr),   0);
        chk_eq("rst_wrdata", 32'(Mem_WrData), 0);
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
        chk_eq("rst_cnt",    32'(Cycle_Cnt),  0);
`endif
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Run A: directed corner messages plus random fill
        randomize_msgs();
        lo_b[0] = 8'h00; hi_b[0] = 8'h00;
        lo_b[1] = 8'hFF; hi_b[1] = 8'h07;
        lo_b[2] = 8'h01; hi_b[2] = 8'h00;
        lo_b[3] = 8'h00; hi_b[3] = 8'h04;
        lo_b[4] = 8'h00; hi_b[4] = 8'hF8;
        load_mem();
        run_seq(1'b0, de, st, lw, bg);
        chk_eq("a_done_edge", 32'(de), 76);
        chk_eq("a_strobes",   32'(st), 30);
        chk_eq("a_low_wr",    32'(lw), 0);
        chk_eq("a_busy_gap",  32'(bg), 0);
        chk_eq("a_busy_end",  32'(Busy), 0);
        chk_eq("a_zero",  32'({mem[DST_BASE+1], mem[DST_BASE]}),     32'h0000);
        chk_eq("a_ones",  32'({mem[DST_BASE+3], mem[DST_BASE+2]}),   32'hFFFF);
        chk_eq("a_d001",  32'({mem[DST_BASE+5], mem[DST_BASE+4]}),   32'h000F);
        chk_eq("a_d400",  32'({mem[DST_BASE+7], mem[DST_BASE+6]}),   32'h8117);
        chk_eq("a_junk",  32'({mem[DST_BASE+9], mem[DST_BASE+8]}),   32'h0000);
        check_results("a");
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
        chk_eq("a_cnt", 32'(Cycle_Cnt), 75);
`endif
        repeat (3) @(posedge Clk);
        #1;
        chk_eq("a_done_hold", 32'(Done), 1);

        // Run B: Start held and re-pulsed mid-run must not restart
        randomize_msgs();
        load_mem();
        run_seq(1'b1, de, st, lw, bg);
        chk_eq("b_done_edge", 32'(de), 76);
        chk_eq("b_strobes",   32'(st), 30);
        chk_eq("b_busy_gap",  32'(bg), 0);
        check_results("b");

        // Run C: reset during WR_LO of message 3, then a clean run
        randomize_msgs();
        load_mem();
        Start = 1'b1;
        found = 0;
        for (int n = 0; n < 100 && found == 0; n++) begin
            @(posedge Clk);
            #1;
            Start = 1'b0;
            if (Mem_WrEn && (Mem_Addr == AW'(DST_BASE + 6))) found = 1;
        end
        chk_eq("c_reached_wrlo3", 32'(found), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk_eq("c_abort_wren", 32'(Mem_WrEn), 0);
        chk_eq("c_abort_busy", 32'(Busy),     0);
        chk_eq("c_abort_done", 32'(Done),     0);
        chk_eq("c_abort_addr", 32'(Mem_Addr), 0);
        @(posedge Clk);
        #1;
        chk_eq("c_no_wr_lo3", 32'(mem[DST_BASE + 6]), 32'hAA);
        chk_eq("c_no_wr_hi3", 32'(mem[DST_BASE + 7]), 32'hAA);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        run_seq(1'b0, de, st, lw, bg);
        chk_eq("c_done_edge", 32'(de), 76);
        chk_eq("c_strobes",   32'(st), 30);
        check_results("c");
`ifdef HAMMING_SEQ_CYCLE_CNT_EN
        chk_eq("c_cnt", 32'(Cycle_Cnt), 75);
        repeat (4) @(posedge Clk);
        #1;
        chk_eq("c_cnt_hold", 32'(Cycle_Cnt), 75);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hamming_enc_seq
`default_nettype wire
